anchor_range_gen: RTL and testbench
===================================

ANCHOR_RANGE_GEN -- requirements
Module: anchor_range_gen

Interface
REQ-001 SHALL have parameter N, default 8, signed coordinate width of every x/y value.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port x_anchor  input  N  signed anchor x (xB).
REQ-007 SHALL have port y_anchor  input  N  signed anchor y (yB).
REQ-008 SHALL have port x_target  input  N  signed target x (xD).
REQ-009 SHALL have port y_target  input  N  signed target y (yD).
REQ-010 SHALL have port out_valid  output  1  descriptor valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the descriptor.
REQ-012 SHALL have port desc  output  3N+1  circle descriptor {x_anchor[N-1:0], y_anchor[N-1:0], r[N:0]}; r is non-negative, N+1-bit signed, same packing as the intersection solver's circle inputs.
REQ-013 SHALL have port sat  output  1  r was clipped to 2^N-1.

Function
REQ-014 SHALL implement FSM states IDLE, SQR, ROOT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid && in_ready, and all four coordinates are registered then.
REQ-016 SQR (1 cycle) SHALL compute dx = x_target - x_anchor and dy = y_target - y_anchor at N+1 bits, then d2 = dx*dx + dy*dy as unsigned 2N+3 bits, without overflow.
REQ-017 ROOT SHALL compute floor(sqrt(d2)) by restoring bit-serial square root, one result bit per cycle, N+2 cycles, MSB first.
REQ-018 out_valid SHALL rise exactly N+4 cycles after the accepting edge (SQR 1 + ROOT N+2 + register 1), independent of the data.
REQ-019 If root > 2^N-1, r SHALL be 2^N-1 and sat SHALL be 1; otherwise r = root and sat = 0.
REQ-020 In DONE, desc, sat and out_valid SHALL remain stable until out_valid && out_ready; the FSM then goes to IDLE, with out_valid low on the next cycle.
REQ-021 in_ready SHALL stay 0 while out_valid is 1; back-to-back throughput is one result per N+5 cycles minimum.
REQ-022 in_valid outside IDLE SHALL be ignored; inputs changing after acceptance SHALL NOT affect the result.
REQ-023 d2 = 0 SHALL give r = 0, sat = 0.

Reset
REQ-024 rst_n low SHALL force IDLE and set in_ready=1 after release, with out_valid=0, desc=0, sat=0 and all internal registers 0, regardless of state.
REQ-025 Reset mid-ROOT or mid-DONE SHALL discard the request with no output produced.

Configuration
REQ-026 With ANCHOR_RANGE_ROUND_EN defined, root SHALL be rounded to nearest: incremented by 1 when the final remainder d2 - root^2 exceeds root; saturation SHALL apply after rounding; latency SHALL be unchanged.
REQ-027 Without ANCHOR_RANGE_ROUND_EN, root SHALL be floor(sqrt(d2)).

Structure
REQ-028 A shared package triloc_pkg SHALL hold the FSM state enum, the descriptor-width constant (3N+1) and the r-width constant (N+1).
REQ-029 The bit-serial root SHALL be a sub-module isqrt_seq (start/busy/done, width parameter) instantiated once.

Verification (N=8)
REQ-030 anchor (0,0), target (3,4) -> r=5, sat=0, desc={8'h00,8'h00,9'd5}, out_valid 12 cycles after acceptance.
REQ-031 anchor (-128,-128), target (127,127) -> d2=130050, r=255, sat=1.
REQ-032 anchor (0,0), target (2,2) -> r=2 with the macro undefined; r=3 with ANCHOR_RANGE_ROUND_EN defined.
REQ-033 out_ready held 0 for 5 cycles after out_valid -> desc and out_valid stable, in_ready=0; the in_valid pulse during the stall is dropped.
REQ-034 rst_n pulsed low 4 cycles into ROOT -> out_valid never asserts for that request; in_ready=1 after release; the next request (anchor (1,1), target (4,5)) returns r=5.
REQ-035 anchor = target = (-7,9) -> r=0, sat=0.

Source files
------------

// File: rtl/anchor_range_gen_pkg.sv
// ---------------------------------------------------------------------------
// triloc_pkg -- shared definitions for the trilateration front end.
//   * state_e      : FSM states of anchor_range_gen
//   * desc_width() : circle descriptor width {x[N-1:0], y[N-1:0], r[N:0]}
//   * r_width()    : radius width (non-negative, N+1-bit signed)
//   * DESC_W/R_W   : the same constants for the default N = 8
// ---------------------------------------------------------------------------
package triloc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int N_DEF  = 8;
    localparam int DESC_W = 3 * N_DEF + 1;
    localparam int R_W    = N_DEF + 1;

    function automatic int desc_width(input int n);
        return 3 * n + 1;
    endfunction

    function automatic int r_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/anchor_range_gen_if.sv
// ---------------------------------------------------------------------------
// anchor_range_gen_if -- request/descriptor handshake bundle.
//   master : requester + consumer side (drives in_valid, coordinates, out_ready)
//   slave  : anchor_range_gen side (drives in_ready, out_valid, desc, sat)
// Signals: in_valid/in_ready, x_anchor, y_anchor, x_target, y_target (N-bit
// signed), out_valid/out_ready, desc (3N+1), sat.
// ---------------------------------------------------------------------------
interface anchor_range_gen_if #(parameter int N = 8);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [N-1:0]                          x_anchor;
    logic [N-1:0]                          y_anchor;
    logic [N-1:0]                          x_target;
    logic [N-1:0]                          y_target;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [triloc_pkg::desc_width(N)-1:0]  desc;
    logic                                  sat;

    modport master (
        output in_valid, x_anchor, y_anchor, x_target, y_target, out_ready,
        input  in_ready, out_valid, desc, sat
    );

    modport slave (
        input  in_valid, x_anchor, y_anchor, x_target, y_target, out_ready,
        output in_ready, out_valid, desc, sat
    );

endinterface

// File: rtl/anchor_range_gen_isqrt_seq.sv
// ---------------------------------------------------------------------------
// isqrt_seq -- restoring bit-serial integer square root, one root bit per
// cycle, MSB first, W cycles after the start cycle.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_start     : load i_operand and begin (ignored while busy)
//   i_operand   : 2W-bit unsigned radicand
//   o_busy      : iteration in progress
//   o_done      : one-cycle pulse, o_root/o_rem valid from then until next start
//   o_root      : floor(sqrt(i_operand)), W bits
//   o_rem       : i_operand - o_root^2, W+1 bits
// ---------------------------------------------------------------------------
module isqrt_seq #(
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [2*W-1:0] i_operand,
    output logic           o_busy,
    output logic           o_done,
    output logic [W-1:0]   o_root,
    output logic [W:0]     o_rem
);

    localparam int RW = W + 1;
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_op;
    logic [RW-1:0]  r_rem;
    logic [W-1:0]   r_root;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    logic [RW+1:0]  w_shift;
    logic [RW+1:0]  w_trial;
    logic           w_ge;

    // One restoring step: bring down the next bit pair, try subtracting 4q+1.
    always_comb begin
        w_shift = {r_rem, r_op[2*W-1:2*W-2]};
        w_trial = {1'b0, r_root, 2'b01};
        w_ge    = (w_shift >= w_trial);
    end

    // Iteration registers: load on start, then W steps while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_op   <= i_operand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CW'(W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_op   <= {r_op[2*W-3:0], 2'b00};
            r_rem  <= w_ge ? RW'(w_shift - w_trial) : RW'(w_shift);
            r_root <= {r_root[W-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_root = r_root;
    assign o_rem  = r_rem;

endmodule

// File: rtl/anchor_range_gen.sv
// ---------------------------------------------------------------------------
// anchor_range_gen -- turns an anchor/target coordinate pair into a circle
// descriptor {x_anchor, y_anchor, r} with r = sqrt((xD-xB)^2 + (yD-yB)^2),
// clipped to 2^N-1 (sat flags the clip). Result appears N+4 cycles after the
// accepting edge and is held until out_ready.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : anchor_range_gen_if.slave (request in, descriptor out)
// Build option: define ANCHOR_RANGE_ROUND_EN to round r to nearest instead of
// truncating (same latency, saturation applied after rounding).
// ---------------------------------------------------------------------------
module anchor_range_gen
    import triloc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    anchor_range_gen_if.slave    bus
);

    localparam int K     = N + 2;
    localparam int DW    = desc_width(N);
    localparam int RWID  = r_width(N);

`ifdef ANCHOR_RANGE_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    state_e          r_state;
    state_e          w_next_state;
    logic            w_accept;
    logic            w_start;
    logic            w_load_out;
    logic            w_release;

    logic [N-1:0]    r_xa;
    logic [N-1:0]    r_ya;
    logic [N-1:0]    r_xt;
    logic [N-1:0]    r_yt;

    logic [DW-1:0]   r_desc;
    logic            r_sat;
    logic            r_out_valid;

    logic [N:0]      w_dx;
    logic [N:0]      w_dy;
    logic [2*N+1:0]  w_dx_ext;
    logic [2*N+1:0]  w_dy_ext;
    logic [2*N+1:0]  w_dx_sq;
    logic [2*N+1:0]  w_dy_sq;
    logic [2*N+2:0]  w_d2;

    logic            w_busy;
    logic            w_done;
    logic [K-1:0]    w_root;
    logic [K:0]      w_rem;
    logic            w_round_up;
    logic [K:0]      w_root_adj;
    logic            w_sat;
    logic [RWID-1:0] w_r;

    // Differences at N+1 bits cannot overflow; squares are formed on
    // sign-extended operands so the low 2N+2 product bits are exact.
    always_comb begin
        w_dx     = {r_xt[N-1], r_xt} - {r_xa[N-1], r_xa};
        w_dy     = {r_yt[N-1], r_yt} - {r_ya[N-1], r_ya};
        w_dx_ext = {{(N+1){w_dx[N]}}, w_dx};
        w_dy_ext = {{(N+1){w_dy[N]}}, w_dy};
        w_dx_sq  = w_dx_ext * w_dx_ext;
        w_dy_sq  = w_dy_ext * w_dy_ext;
        w_d2     = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
    end

    isqrt_seq #(.W(K)) u_isqrt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_operand ({1'b0, w_d2}),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_root    (w_root),
        .o_rem     (w_rem)
    );

    // Optional round-to-nearest: remainder above root means the true root
    // is past the half-way point. Clip to 2^N-1 afterwards.
    always_comb begin
        w_round_up = (w_rem > {1'b0, w_root}) & ROUND_EN;
        w_root_adj = {1'b0, w_root} + {{K{1'b0}}, w_round_up};
        w_sat      = (w_root_adj > {{(K+1-N){1'b0}}, {N{1'b1}}});
        w_r        = w_sat ? {1'b0, {N{1'b1}}} : w_root_adj[N:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_load_out   = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SQR;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SQR: begin
                if (!w_busy) begin
                    w_start      = 1'b1;
                    w_next_state = ROOT;
                end else begin
                    w_next_state = SQR;
                end
            end
            ROOT: begin
                if (w_done) begin
                    w_load_out   = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_next_state = ROOT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Coordinates are captured only on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xa <= '0;
            r_ya <= '0;
            r_xt <= '0;
            r_yt <= '0;
        end else if (w_accept) begin
            r_xa <= bus.x_anchor;
            r_ya <= bus.y_anchor;
            r_xt <= bus.x_target;
            r_yt <= bus.y_target;
        end else begin
            r_xa <= r_xa;
            r_ya <= r_ya;
            r_xt <= r_xt;
            r_yt <= r_yt;
        end
    end

    // Output registers: loaded when the root completes, held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_desc      <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_desc      <= {r_xa, r_ya, w_r};
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.desc      = r_desc;
    assign bus.sat       = r_sat;

endmodule

// File: tb/tb_anchor_range_gen.sv
module tb_anchor_range_gen;

    localparam int N = 8;

    logic clk;
    logic rst_n;

    anchor_range_gen_if #(.N(N)) bus ();

    anchor_range_gen #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] xa;
        logic [7:0] ya;
        logic [7:0] xt;
        logic [7:0] yt;
        logic [8:0] r_floor;
        logic [8:0] r_round;
        logic       sat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait for out_valid.
    task automatic run_req(input logic [7:0] xa, input logic [7:0] ya,
                           input logic [7:0] xt, input logic [7:0] yt,
                           output int lat, output logic [24:0] d, output logic s);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_anchor = xa;
        bus.y_anchor = ya;
        bus.x_target = xt;
        bus.y_target = yt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x_anchor = 8'($urandom);
        bus.y_anchor = 8'($urandom);
        bus.x_target = 8'($urandom);
        bus.y_target = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        d = bus.desc;
        s = bus.sat;
    endtask

    // Accept the descriptor and verify the block returns to idle.
    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_release", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [24:0] d;
        logic [24:0] d_hold;
        logic       s;
        logic [8:0] r_exp;
        bit         seen;

        vecs[0]  = '{8'h00, 8'h00, 8'h03, 8'h04, 9'd5,   9'd5,   1'b0};
        vecs[1]  = '{8'h80, 8'h80, 8'h7F, 8'h7F, 9'd255, 9'd255, 1'b1};
        vecs[2]  = '{8'h00, 8'h00, 8'h02, 8'h02, 9'd2,   9'd3,   1'b0};
        vecs[3]  = '{8'hF9, 8'h09, 8'hF9, 8'h09, 9'd0,   9'd0,   1'b0};
        vecs[4]  = '{8'h01, 8'h01, 8'h04, 8'h05, 9'd5,   9'd5,   1'b0};
        vecs[5]  = '{8'h0A, 8'hEC, 8'hF6, 8'h14, 9'd44,  9'd45,  1'b0};
        vecs[6]  = '{8'h7F, 8'h00, 8'h80, 8'h00, 9'd255, 9'd255, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 8'h7F, 8'h7F, 9'd179, 9'd180, 1'b0};
        vecs[8]  = '{8'h80, 8'h00, 8'h7F, 8'h01, 9'd255, 9'd255, 1'b0};
        vecs[9]  = '{8'h80, 8'h00, 8'h7F, 8'h17, 9'd255, 9'd255, 1'b1};
        vecs[10] = '{8'h05, 8'h05, 8'h06, 8'h05, 9'd1,   9'd1,   1'b0};
        vecs[11] = '{8'h00, 8'h00, 8'h01, 8'h01, 9'd1,   9'd1,   1'b0};
        vecs[12] = '{8'h00, 8'h00, 8'hFD, 8'hFD, 9'd4,   9'd4,   1'b0};
        vecs[13] = '{8'h00, 8'h00, 8'h05, 8'h05, 9'd7,   9'd7,   1'b0};
        vecs[14] = '{8'h00, 8'h00, 8'h04, 8'h04, 9'd5,   9'd6,   1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_anchor = 8'h00;
        bus.y_anchor = 8'h00;
        bus.x_target = 8'h00;
        bus.y_target = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_desc", 32'(bus.desc), 32'd0);
        chk("reset_sat", 32'(bus.sat), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
`ifdef ANCHOR_RANGE_ROUND_EN
            r_exp = vecs[i].r_round;
`else
            r_exp = vecs[i].r_floor;
`endif
            chk("in_ready_before_req", 32'(bus.in_ready), 32'd1);
            run_req(vecs[i].xa, vecs[i].ya, vecs[i].xt, vecs[i].yt, lat, d, s);
            chk($sformatf("latency_v%0d", i), 32'(lat), 32'd12);
            chk($sformatf("desc_v%0d", i), 32'(d), 32'({vecs[i].xa, vecs[i].ya, r_exp}));
            chk($sformatf("sat_v%0d", i), 32'(s), 32'(vecs[i].sat));
            release_out();
        end

        // Stall: out_ready low for 5 cycles, in_valid pulse must be dropped.
        run_req(8'h00, 8'h00, 8'h03, 8'h04, lat, d, s);
        chk("stall_latency", 32'(lat), 32'd12);
        d_hold = 25'({8'h00, 8'h00, 9'd5});
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.in_valid = 1'b1;
                bus.x_anchor = 8'h11;
                bus.x_target = 8'h55;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_desc", 32'(bus.desc), 32'(d_hold));
        end
        bus.in_valid = 1'b0;
        release_out();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || !bus.in_ready) seen = 1'b1;
        end
        chk("stall_pulse_dropped", 32'(seen), 32'd0);

        // Reset four cycles into ROOT discards the request.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_anchor = 8'h00;
        bus.y_anchor = 8'h00;
        bus.x_target = 8'h03;
        bus.y_target = 8'h04;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("root_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("root_rst_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("root_rst_no_output", 32'(seen), 32'd0);
        run_req(8'h01, 8'h01, 8'h04, 8'h05, lat, d, s);
        chk("after_rst_latency", 32'(lat), 32'd12);
        chk("after_rst_desc", 32'(d), 32'({8'h01, 8'h01, 9'd5}));
        chk("after_rst_sat", 32'(s), 32'd0);

        // Reset while DONE clears the held descriptor.
        #1;
        rst_n = 1'b0;
        #1;
        chk("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("done_rst_desc", 32'(bus.desc), 32'd0);
        chk("done_rst_sat", 32'(bus.sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("done_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
